// File: rtl/barrel_shifter_arbiter.sv
// Round-robin sharing of one right barrel shifter between two valid/ready requesters,
// with a one-deep output register tagged by requester ID.

module barrel_shifter_right #(
  parameter int DATA_WIDTH = 16,
  parameter int SA_WIDTH   = $clog2(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [SA_WIDTH-1:0]   sa,
  input  logic                  st,
  output logic [DATA_WIDTH-1:0] result
);
  // One guard bit above the operand carries the fill value, so a single
  // arithmetic shift covers both logical (fill 0) and arithmetic (fill MSB).
  logic signed [DATA_WIDTH:0] ext;
  logic signed [DATA_WIDTH:0] shifted;

  assign ext     = {st & data[DATA_WIDTH-1], data};
  assign shifted = ext >>> sa;
  assign result  = shifted[DATA_WIDTH-1:0];
endmodule

module barrel_shifter_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int SA_WIDTH   = $clog2(DATA_WIDTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req0_valid,
  output logic                  o_req0_ready,
  input  logic [DATA_WIDTH-1:0] i_req0_data,
  input  logic [SA_WIDTH-1:0]   i_req0_sa,
  input  logic                  i_req0_st,
  input  logic                  i_req1_valid,
  output logic                  o_req1_ready,
  input  logic [DATA_WIDTH-1:0] i_req1_data,
  input  logic [SA_WIDTH-1:0]   i_req1_sa,
  input  logic                  i_req1_st,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_id
);
  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] data_p1;
  logic                  id_p1;
  logic                  ptr;

  logic                  can_accept;
  logic                  gnt_vld_p0;
  logic                  gnt_id_p0;
  logic                  accept_p0;
  logic [DATA_WIDTH-1:0] mux_data_p0;
  logic [SA_WIDTH-1:0]   mux_sa_p0;
  logic                  mux_st_p0;
  logic [DATA_WIDTH-1:0] shift_p0;

  // Stage p0: arbitration, operand mux and the shared shifter
  assign can_accept = !vld_p1 || i_ready;

  always_comb begin
    gnt_vld_p0 = i_req0_valid || i_req1_valid;
    gnt_id_p0  = 1'b0;
    if (i_req0_valid && i_req1_valid) gnt_id_p0 = ptr;
    else if (i_req1_valid)            gnt_id_p0 = 1'b1;
  end

  assign o_req0_ready = can_accept && gnt_vld_p0 && !gnt_id_p0 && !i_rst;
  assign o_req1_ready = can_accept && gnt_vld_p0 &&  gnt_id_p0 && !i_rst;
  assign accept_p0    = o_req0_ready || o_req1_ready;

  // With no grant the select stays at 0, so requester 0 drives the idle shifter.
  assign mux_data_p0 = gnt_id_p0 ? i_req1_data : i_req0_data;
  assign mux_sa_p0   = gnt_id_p0 ? i_req1_sa   : i_req0_sa;
  assign mux_st_p0   = gnt_id_p0 ? i_req1_st   : i_req0_st;

  barrel_shifter_right #(
    .DATA_WIDTH (DATA_WIDTH),
    .SA_WIDTH   (SA_WIDTH)
  ) u_shifter (
    .data   (mux_data_p0),
    .sa     (mux_sa_p0),
    .st     (mux_st_p0),
    .result (shift_p0)
  );

  // Stage p1: output register; reload and drain may happen on the same edge
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      id_p1   <= 1'b0;
      ptr     <= 1'b0;
    end else if (accept_p0) begin
      vld_p1  <= 1'b1;
      data_p1 <= shift_p0;
      id_p1   <= gnt_id_p0;
      ptr     <= !gnt_id_p0;
    end else if (i_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign o_valid = vld_p1;
  assign o_data  = data_p1;
  assign o_id    = id_p1;
endmodule

// File: tb/tb_barrel_shifter_arbiter.sv
// Self-checking bench for barrel_shifter_arbiter: directed scenarios plus
// randomized traffic against a behavioural arbiter/shifter model.

module tb_barrel_shifter_arbiter;
  localparam int DW = 16;
  localparam int SW = 4;

  logic          clk;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] req0_data, req1_data;
  logic [SW-1:0] req0_sa, req1_sa;
  logic          req0_st, req1_st;
  logic          out_valid, out_ready, out_id;
  logic [DW-1:0] out_data;

  int tests = 0;
  int fails = 0;

  barrel_shifter_arbiter #(.DATA_WIDTH(DW), .SA_WIDTH(SW)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req0_valid (req0_valid),
    .o_req0_ready (req0_ready),
    .i_req0_data  (req0_data),
    .i_req0_sa    (req0_sa),
    .i_req0_st    (req0_st),
    .i_req1_valid (req1_valid),
    .o_req1_ready (req1_ready),
    .i_req1_data  (req1_data),
    .i_req1_sa    (req1_sa),
    .i_req1_st    (req1_st),
    .o_valid      (out_valid),
    .i_ready      (out_ready),
    .o_data       (out_data),
    .o_id         (out_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Right shift as integer division: floor for arithmetic negatives, plain for logical.
  function automatic logic [DW-1:0] ref_shift(input logic [DW-1:0] d, input int sa, input logic st);
    int v;
    int p;
    int r;
    p = 1 << sa;
    v = (st && d[DW-1]) ? int'(d) - 65536 : int'(d);
    if (v < 0) r = -((-v + p - 1) / p);
    else       r = v / p;
    ref_shift = r[DW-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [DW-1:0] d0, input logic [SW-1:0] s0, input logic t0,
                       input logic v1, input logic [DW-1:0] d1, input logic [SW-1:0] s1, input logic t1,
                       input logic rdy);
    req0_valid = v0; req0_data = d0; req0_sa = s0; req0_st = t0;
    req1_valid = v1; req1_data = d1; req1_sa = s1; req1_st = t1;
    out_ready  = rdy;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 16'h1234, 4'd1, 0, 1, 16'h5678, 4'd2, 0, 1);
    step();
    #1;
    tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      fails++; $display("FAIL reset_readies: got %b%b expected 00", req0_ready, req1_ready);
    end
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    tests++; if (out_data !== 16'h0) begin fails++; $display("FAIL reset_data: got %h expected 0000", out_data); end
    tests++; if (out_id !== 1'b0) begin fails++; $display("FAIL reset_id: got %b expected 0", out_id); end
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
  endtask

  task automatic test_shift_modes();
    logic [DW-1:0] vd [4] = '{16'h8000, 16'h8000, 16'h7FFF, 16'hABCD};
    logic [SW-1:0] vs [4] = '{4'd4, 4'd4, 4'd15, 4'd0};
    logic          vt [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [DW-1:0] ve [4] = '{16'h0800, 16'hF800, 16'h0000, 16'hABCD};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, vd[i], vs[i], vt[i], 0, 0, 0, 0, 1);
      #1;
      tests++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
        fails++; $display("FAIL shift_ready[%0d]: got %b%b expected 10", i, req0_ready, req1_ready);
      end
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      tests++; if (out_valid !== 1'b1 || out_data !== ve[i] || out_id !== 1'b0) begin
        fails++; $display("FAIL shift_result[%0d]: got v=%b d=%h id=%b expected v=1 d=%h id=0",
                          i, out_valid, out_data, out_id, ve[i]);
      end
    end
    step();
    tests++; if (out_valid !== 1'b0 || out_data !== 16'hABCD) begin
      fails++; $display("FAIL drain_hold: got v=%b d=%h expected v=0 d=abcd", out_valid, out_data);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1, 16'h0010, 4'd1, 0, 1, 16'h0100, 4'd4, 0, 1);
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
        fails++; $display("FAIL rr_ready[%0d]: got %b%b", i, req0_ready, req1_ready);
      end
      step();
      tests++; if (out_valid !== 1'b1 || out_id !== 1'(i % 2) ||
                   out_data !== ((i % 2 == 0) ? 16'h0008 : 16'h0010)) begin
        fails++; $display("FAIL rr_result[%0d]: got v=%b id=%b d=%h", i, out_valid, out_id, out_data);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(1, 16'h0010, 4'd1, 0, 0, 0, 0, 0, 1);
    step();
    drive(1, 16'h0010, 4'd1, 0, 1, 16'h0100, 4'd4, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        fails++; $display("FAIL bp_ready[%0d]: got %b%b expected 00", i, req0_ready, req1_ready);
      end
      step();
      tests++; if (out_valid !== 1'b1 || out_data !== 16'h0008 || out_id !== 1'b0) begin
        fails++; $display("FAIL bp_hold[%0d]: got v=%b d=%h id=%b expected v=1 d=0008 id=0",
                          i, out_valid, out_data, out_id);
      end
    end
    out_ready = 1'b1;
    #1;
    tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
      fails++; $display("FAIL bp_release_ready: got %b%b expected 01", req0_ready, req1_ready);
    end
    step();
    tests++; if (out_valid !== 1'b1 || out_data !== 16'h0010 || out_id !== 1'b1) begin
      fails++; $display("FAIL bp_release: got v=%b d=%h id=%b expected v=1 d=0010 id=1", out_valid, out_data, out_id);
    end
  endtask

  task automatic test_no_starve();
    do_reset();
    drive(0, 16'h0010, 4'd1, 0, 1, 16'h0100, 4'd4, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (out_valid !== 1'b1 || out_id !== 1'b1) begin
        fails++; $display("FAIL solo_req1[%0d]: got v=%b id=%b expected v=1 id=1", i, out_valid, out_id);
      end
    end
    req0_valid = 1'b1;
    #1;
    tests++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      fails++; $display("FAIL starve_ready: got %b%b expected 10", req0_ready, req1_ready);
    end
    step();
    tests++; if (out_id !== 1'b0 || out_data !== 16'h0008) begin
      fails++; $display("FAIL starve_result: got id=%b d=%h expected id=0 d=0008", out_id, out_data);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1, 16'h0010, 4'd1, 0, 0, 0, 0, 0, 1);
    step();
    drive(1, 16'h0010, 4'd1, 0, 1, 16'h0100, 4'd4, 0, 0);
    rst = 1'b1;
    #1;
    tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      fails++; $display("FAIL midrst_ready: got %b%b expected 00", req0_ready, req1_ready);
    end
    step();
    tests++; if (out_valid !== 1'b0 || out_data !== 16'h0 || out_id !== 1'b0) begin
      fails++; $display("FAIL midrst_clear: got v=%b d=%h id=%b expected v=0 d=0000 id=0", out_valid, out_data, out_id);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    tests++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      fails++; $display("FAIL midrst_ptr: got %b%b expected 10", req0_ready, req1_ready);
    end
    step();
    tests++; if (out_valid !== 1'b1 || out_id !== 1'b0) begin
      fails++; $display("FAIL midrst_first: got v=%b id=%b expected v=1 id=0", out_valid, out_id);
    end
  endtask

  task automatic test_random();
    logic          m_valid, m_id, m_ptr, g, have, can, e0, e1;
    logic [DW-1:0] m_data, exp;
    logic [DW-1:0] sb0[$];
    logic [DW-1:0] sb1[$];
    do_reset();
    m_valid = 0; m_id = 0; m_ptr = 0; m_data = '0;
    for (int n = 0; n < 10000; n++) begin
      drive($urandom_range(0, 9) < 6, DW'($urandom), SW'($urandom), 1'($urandom),
            $urandom_range(0, 9) < 6, DW'($urandom), SW'($urandom), 1'($urandom),
            $urandom_range(0, 9) < 7);
      #1;
      tests++; if (out_valid !== m_valid || (m_valid && (out_data !== m_data || out_id !== m_id))) begin
        fails++; $display("FAIL rand_out[%0d]: got v=%b d=%h id=%b expected v=%b d=%h id=%b",
                          n, out_valid, out_data, out_id, m_valid, m_data, m_id);
      end
      can  = !m_valid || out_ready;
      have = req0_valid || req1_valid;
      g    = (req0_valid && req1_valid) ? m_ptr : req1_valid;
      e0   = can && have && !g;
      e1   = can && have && g;
      tests++; if (req0_ready !== e0 || req1_ready !== e1) begin
        fails++; $display("FAIL rand_ready[%0d]: got %b%b expected %b%b", n, req0_ready, req1_ready, e0, e1);
      end
      tests++; if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
        fails++; $display("FAIL rand_both_ready[%0d]: got 11 expected at most one", n);
      end
      if (out_valid === 1'b1 && out_ready) begin
        tests++;
        if (out_id === 1'b1 ? sb1.size() == 0 : sb0.size() == 0) begin
          fails++; $display("FAIL rand_sb_empty[%0d]: got id=%b d=%h expected a queued result", n, out_id, out_data);
        end else begin
          exp = (out_id === 1'b1) ? sb1.pop_front() : sb0.pop_front();
          if (out_data !== exp) begin
            fails++; $display("FAIL rand_sb[%0d]: got id=%b d=%h expected d=%h", n, out_id, out_data, exp);
          end
        end
      end
      if (e0 || e1) begin
        exp = g ? ref_shift(req1_data, int'(req1_sa), req1_st) : ref_shift(req0_data, int'(req0_sa), req0_st);
        if (g) sb1.push_back(exp); else sb0.push_back(exp);
        m_valid = 1'b1; m_data = exp; m_id = g; m_ptr = !g;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_shift_modes();
    test_back_to_back();
    test_backpressure();
    test_no_starve();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
